// File: rtl/memory_access_pkg.sv
// rtl/memory_access_pkg.sv - memory_access pipeline constants and FSM state encoding
package memory_access_pkg;

  localparam int MEM_LAT_DEF = 1;
  localparam int MEM_LAT_MAX = 4;
  localparam int CNT_W       = $clog2(MEM_LAT_MAX + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/memory_access_mem_wait_counter.sv
// rtl/memory_access_mem_wait_counter.sv - loadable down-counter timing the data-memory read latency
module mem_wait_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - memory stage: loads/stores to synchronous data memory, registered write-back bundle
module memory_access
  import memory_access_pkg::*;
#(
  parameter int ADDR    = 16,
  parameter int W_OPR   = 32,
  parameter int W_RD    = 4,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             v_i,
  output logic             stall_o,
  input  logic             ld_i,
  input  logic             st_i,
  input  logic [ADDR-1:0]  addr_i,
  input  logic [W_OPR-1:0] data_i,
  input  logic             wb_i,
  input  logic [W_RD-1:0]  wb_r_i,
  input  logic [W_OPR-1:0] result_i,
  output logic [ADDR-1:0]  mem_addr_o,
  output logic             mem_write_o,
  output logic [W_OPR-1:0] mem_data_o,
  input  logic [W_OPR-1:0] mem_data_i,
  output logic             v_o,
  input  logic             stall_i,
  output logic             wb_o,
  output logic [W_RD-1:0]  wb_r_o,
  output logic [W_OPR-1:0] result_o
);

  localparam logic [CNT_W-1:0] LAT_VAL = CNT_W'(MEM_LAT);

  state_t            state, state_nxt;
  logic              accept, is_ld, is_st, in_wait, cnt_done, ld_done, load_ok;
  logic              ld_wb;
  logic [W_RD-1:0]   ld_wb_r;

  assign in_wait = (state == S_WAIT);
  assign stall_o = in_wait | (v_o & stall_i);
  assign accept  = v_i & ~stall_o;
  // A load wins over a simultaneous store; the store is dropped.
  assign is_ld   = accept & ld_i;
  assign is_st   = accept & st_i & ~ld_i;
  assign ld_done = in_wait & cnt_done;
  assign load_ok = ~(v_o & stall_i);

  mem_wait_counter #(
    .W (CNT_W)
  ) u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (is_ld),
    .en       (in_wait),
    .load_val (LAT_VAL),
    .done     (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (is_ld) state_nxt = S_WAIT;
      S_WAIT:  if (cnt_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      mem_write_o <= 1'b0;
      ld_wb       <= 1'b0;
      ld_wb_r     <= '0;
    end else begin
      mem_write_o <= is_st;
      if (is_ld || is_st) mem_addr_o <= addr_i;
      if (is_st) mem_data_o <= data_i;
      if (is_ld) begin
        ld_wb   <= wb_i;
        ld_wb_r <= wb_r_i;
      end
    end
  end

  // v_o is always 0 in S_WAIT, so a completing load never meets a held bundle.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_o      <= 1'b0;
      wb_o     <= 1'b0;
      wb_r_o   <= '0;
      result_o <= '0;
    end else if (load_ok) begin
      if (ld_done) begin
        v_o      <= 1'b1;
        wb_o     <= ld_wb;
        wb_r_o   <= ld_wb_r;
        result_o <= mem_data_i;
      end else if (accept && !ld_i) begin
        v_o      <= 1'b1;
        wb_o     <= wb_i & ~st_i;
        wb_r_o   <= wb_r_i;
        result_o <= result_i;
      end else begin
        v_o  <= 1'b0;
        wb_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - directed table-driven bench for memory_access at MEM_LAT=1 and MEM_LAT=3
module tb_memory_access;

  typedef struct {
    logic        rst, v, ld, st, wb;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  wbr;
    logic [31:0] res;
    logic        sin;
    logic        ev, ewb;
    logic [3:0]  ewbr;
    logic [31:0] eres;
    logic        est, emw, cm;
    logic [15:0] emaddr;
    logic [31:0] emdata;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        v_i [2], ld_i [2], st_i [2], wb_i [2], stall_i [2];
  logic        stall_o [2], mem_write_o [2], v_o [2], wb_o [2];
  logic [15:0] addr_i [2], mem_addr_o [2];
  logic [31:0] data_i [2], result_i [2], mem_data_o [2], mem_data_i [2], result_o [2];
  logic [3:0]  wb_r_i [2], wb_r_o [2];

  logic [31:0] mem [2][256];
  logic [31:0] qp [2][3];

  int pass_cnt = 0;
  int total_cnt = 0;
  vec_t tbl [14];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  memory_access u_dut0 (
    .clk(clk), .reset(reset), .v_i(v_i[0]), .stall_o(stall_o[0]), .ld_i(ld_i[0]), .st_i(st_i[0]),
    .addr_i(addr_i[0]), .data_i(data_i[0]), .wb_i(wb_i[0]), .wb_r_i(wb_r_i[0]), .result_i(result_i[0]),
    .mem_addr_o(mem_addr_o[0]), .mem_write_o(mem_write_o[0]), .mem_data_o(mem_data_o[0]),
    .mem_data_i(mem_data_i[0]), .v_o(v_o[0]), .stall_i(stall_i[0]), .wb_o(wb_o[0]),
    .wb_r_o(wb_r_o[0]), .result_o(result_o[0])
  );

  memory_access #(.MEM_LAT(3)) u_dut1 (
    .clk(clk), .reset(reset), .v_i(v_i[1]), .stall_o(stall_o[1]), .ld_i(ld_i[1]), .st_i(st_i[1]),
    .addr_i(addr_i[1]), .data_i(data_i[1]), .wb_i(wb_i[1]), .wb_r_i(wb_r_i[1]), .result_i(result_i[1]),
    .mem_addr_o(mem_addr_o[1]), .mem_write_o(mem_write_o[1]), .mem_data_o(mem_data_o[1]),
    .mem_data_i(mem_data_i[1]), .v_o(v_o[1]), .stall_i(stall_i[1]), .wb_o(wb_o[1]),
    .wb_r_o(wb_r_o[1]), .result_o(result_o[1])
  );

  function automatic logic [31:0] init_word(input int k, input int i);
    logic [7:0] b;
    b = 8'(i);
    return (k == 1 && i == 2) ? 32'h12 : {b, b, b, b};
  endfunction

  // Synchronous data memory models: DUT0 read latency 1, DUT1 read latency 3.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int i = 0; i < 256; i++) mem[k][i] <= init_word(k, i);
        for (int j = 0; j < 3; j++) qp[k][j] <= '0;
      end else begin
        if (mem_write_o[k]) mem[k][mem_addr_o[k][7:0]] <= mem_data_o[k];
        qp[k][0] <= mem[k][mem_addr_o[k][7:0]];
        qp[k][1] <= qp[k][0];
        qp[k][2] <= qp[k][1];
      end
    end
  end

  always_comb begin
    mem_data_i[0] = qp[0][0];
    mem_data_i[1] = qp[1][2];
  end

  function automatic vec_t row(input logic [31:0] rst, v, ld, st, wb, addr, data, wbr, res, sin,
                               ev, ewb, ewbr, eres, est, emw, cm, emaddr, emdata);
    vec_t r;
    r.rst = rst[0]; r.v = v[0]; r.ld = ld[0]; r.st = st[0]; r.wb = wb[0];
    r.addr = addr[15:0]; r.data = data; r.wbr = wbr[3:0]; r.res = res; r.sin = sin[0];
    r.ev = ev[0]; r.ewb = ewb[0]; r.ewbr = ewbr[3:0]; r.eres = eres;
    r.est = est[0]; r.emw = emw[0]; r.cm = cm[0]; r.emaddr = emaddr[15:0]; r.emdata = emdata;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic run_row(input int k, input string tag, input vec_t r);
    @(negedge clk);
    reset      = r.rst;
    v_i[k]     = r.v;
    ld_i[k]    = r.ld;
    st_i[k]    = r.st;
    wb_i[k]    = r.wb;
    addr_i[k]  = r.addr;
    data_i[k]  = r.data;
    wb_r_i[k]  = r.wbr;
    result_i[k] = r.res;
    stall_i[k] = r.sin;
    #1;
    chk({tag, ".v_o"},         32'(v_o[k]),         32'(r.ev));
    chk({tag, ".wb_o"},        32'(wb_o[k]),        32'(r.ewb));
    chk({tag, ".wb_r_o"},      32'(wb_r_o[k]),      32'(r.ewbr));
    chk({tag, ".result_o"},    result_o[k],         r.eres);
    chk({tag, ".stall_o"},     32'(stall_o[k]),     32'(r.est));
    chk({tag, ".mem_write_o"}, 32'(mem_write_o[k]), 32'(r.emw));
    if (r.cm) begin
      chk({tag, ".mem_addr_o"}, 32'(mem_addr_o[k]), 32'(r.emaddr));
      chk({tag, ".mem_data_o"}, mem_data_o[k],      r.emdata);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      v_i[k] = 0; ld_i[k] = 0; st_i[k] = 0; wb_i[k] = 0; stall_i[k] = 0;
      addr_i[k] = '0; data_i[k] = '0; wb_r_i[k] = '0; result_i[k] = '0;
    end

    //               rst v ld st wb addr data          wbr res   sin ev ewb ewbr eres          est emw cm maddr mdata
    tbl[0]  = row(0, 0, 0, 0, 0, 0, 0,            0, 0,    0,  0, 0, 0, 0,            0, 0, 1, 0, 0);
    tbl[1]  = row(0, 1, 0, 0, 1, 0, 0,            1, 1,    0,  0, 0, 0, 0,            0, 0, 0, 0, 0);
    tbl[2]  = row(0, 1, 0, 0, 1, 0, 0,            2, 2,    0,  1, 1, 1, 1,            0, 0, 0, 0, 0);
    tbl[3]  = row(0, 1, 0, 0, 1, 0, 0,            3, 3,    0,  1, 1, 2, 2,            0, 0, 0, 0, 0);
    tbl[4]  = row(0, 1, 0, 0, 1, 0, 0,            4, 4,    0,  1, 1, 3, 3,            0, 0, 0, 0, 0);
    tbl[5]  = row(0, 1, 0, 1, 1, 5, 32'hDEADBEEF, 9, 'h99, 0,  1, 1, 4, 4,            0, 0, 1, 0, 0);
    tbl[6]  = row(0, 1, 1, 0, 1, 5, 0,            3, 0,    0,  1, 0, 9, 'h99,         0, 1, 1, 5, 32'hDEADBEEF);
    tbl[7]  = row(0, 1, 1, 0, 1, 5, 0,            3, 0,    0,  0, 0, 9, 'h99,         1, 0, 1, 5, 32'hDEADBEEF);
    tbl[8]  = row(0, 1, 1, 0, 1, 5, 0,            3, 0,    0,  0, 0, 9, 'h99,         1, 0, 0, 0, 0);
    tbl[9]  = row(0, 1, 1, 1, 1, 7, 'h55,         6, 0,    0,  1, 1, 3, 32'hDEADBEEF, 0, 0, 1, 5, 32'hDEADBEEF);
    tbl[10] = row(0, 0, 0, 0, 0, 0, 0,            0, 0,    0,  0, 0, 3, 32'hDEADBEEF, 1, 0, 1, 7, 32'hDEADBEEF);
    tbl[11] = row(0, 0, 0, 0, 0, 0, 0,            0, 0,    0,  0, 0, 3, 32'hDEADBEEF, 1, 0, 0, 0, 0);
    tbl[12] = row(0, 0, 0, 0, 0, 0, 0,            0, 0,    0,  1, 1, 6, 32'h07070707, 0, 0, 1, 7, 32'hDEADBEEF);
    tbl[13] = row(0, 0, 0, 0, 0, 0, 0,            0, 0,    0,  0, 0, 6, 32'h07070707, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    for (int i = 0; i < 14; i++) run_row(0, $sformatf("tbl%0d", i), tbl[i]);
    chk("mem7_unchanged", mem[0][7], 32'h07070707);
    chk("mem5_stored",    mem[0][5], 32'hDEADBEEF);

    // Load completing into a 3-cycle downstream hold; the pending ALU op must be taken exactly once.
    run_row(0, "ds0", row(0, 1, 1, 0, 1, 5, 0, 2, 0,     0, 0, 0, 6, 32'h07070707, 0, 0, 0, 0, 0));
    run_row(0, "ds1", row(0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 6, 32'h07070707, 1, 0, 0, 0, 0));
    run_row(0, "ds2", row(0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 6, 32'h07070707, 1, 0, 0, 0, 0));
    run_row(0, "ds3", row(0, 1, 0, 0, 1, 0, 0, 8, 'hAA,  1, 1, 1, 2, 32'hDEADBEEF, 1, 0, 0, 0, 0));
    run_row(0, "ds4", row(0, 1, 0, 0, 1, 0, 0, 8, 'hAA,  1, 1, 1, 2, 32'hDEADBEEF, 1, 0, 0, 0, 0));
    run_row(0, "ds5", row(0, 1, 0, 0, 1, 0, 0, 8, 'hAA,  1, 1, 1, 2, 32'hDEADBEEF, 1, 0, 0, 0, 0));
    run_row(0, "ds6", row(0, 1, 0, 0, 1, 0, 0, 8, 'hAA,  0, 1, 1, 2, 32'hDEADBEEF, 0, 0, 0, 0, 0));
    run_row(0, "ds7", row(0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 1, 1, 8, 'hAA,         0, 0, 0, 0, 0));
    run_row(0, "ds8", row(0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 8, 'hAA,         0, 0, 0, 0, 0));

    // Reset one cycle into a load: the load is abandoned and the next op is taken at once.
    run_row(0, "rs0", row(0, 1, 1, 0, 1, 7, 0, 5, 0,     0, 0, 0, 8, 'hAA,         0, 0, 0, 0, 0));
    run_row(0, "rs1", row(1, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 8, 'hAA,         1, 0, 0, 0, 0));
    run_row(0, "rs2", row(0, 1, 0, 0, 1, 0, 0, 4, 'h31,  0, 0, 0, 0, 0,            0, 0, 1, 0, 0));
    run_row(0, "rs3", row(0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 1, 1, 4, 'h31,         0, 0, 0, 0, 0));
    run_row(0, "rs4", row(0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 4, 'h31,         0, 0, 0, 0, 0));
    run_row(0, "rs5", row(0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0, 4, 'h31,         0, 0, 0, 0, 0));

    // MEM_LAT=3 instance: four stall cycles, result at T+5.
    run_row(1, "l0", row(0, 1, 1, 0, 1, 2, 0, 1, 0,      0, 0, 0, 0, 0,            0, 0, 0, 0, 0));
    run_row(1, "l1", row(0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0,            1, 0, 1, 2, 0));
    run_row(1, "l2", row(0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0,            1, 0, 0, 0, 0));
    run_row(1, "l3", row(0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0,            1, 0, 0, 0, 0));
    run_row(1, "l4", row(0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0,            1, 0, 0, 0, 0));
    run_row(1, "l5", row(0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 1, 1, 1, 'h12,         0, 0, 0, 0, 0));
    run_row(1, "l6", row(0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 1, 'h12,         0, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
